// File: rtl/ce_eq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ce_eq_pkg
// Description : Shared types and burst geometry for the channel-estimator /
//               equalizer burst sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ce_eq_pkg;

  localparam int ACTIVE_SUBCARR = 28;
  localparam int CEST_NUM       = 4;
  localparam int SYMBOL_NUM     = 8;

  localparam int CE_SAMPLES     = CEST_NUM * ACTIVE_SUBCARR;    // 112
  localparam int DATA_SAMPLES   = SYMBOL_NUM * ACTIVE_SUBCARR;  // 224

  // Sample counter / read pointer width (holds up to DATA_SAMPLES)
  localparam int CNT_W = 8;

  localparam logic [CNT_W-1:0] CE_LAST    = CNT_W'(CE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_SAMPLES - 1);
  localparam logic [CNT_W-1:0] DATA_TOTAL = CNT_W'(DATA_SAMPLES);

  typedef enum logic [2:0] {
    ST_CLEAR     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_LOAD_CE   = 3'd2,
    ST_LOAD_DATA = 3'd3,
    ST_WAIT_EQ   = 3'd4,
    ST_DRAIN     = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ce_eq_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ce_eq_skid_fifo
// Description : Small synchronous FIFO absorbing read-latency data while the
//               downstream stalls. Push and pop may coincide, even when full.
// Revision    : 1.0 - initial release
// ============================================================================
module ce_eq_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               din_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               dout_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;

  logic w_pop;
  logic w_push;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push
  assign w_pop  = pop_i && (cnt_q != '0);
  assign w_push = push_i && ((cnt_q != FULL_CNT) || w_pop);

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= (wr_q == LAST_IDX) ? '0 : wr_q + AW'(1);
      end
      if (w_pop) begin
        rd_q <= (rd_q == LAST_IDX) ? '0 : rd_q + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ce_eq_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ce_eq_burst_ctrl
// Description : Burst sequencer for the channel-estimator/equalizer datapath.
//               Clears the datapath, loads CE + data symbols, waits for the
//               equalized buffer, then drains it as a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ce_eq_burst_ctrl
  import ce_eq_pkg::*;
#(
  parameter int READ_LAT = 3,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        s_ready,
  output logic [15:0] eq_din,
  output logic        eq_wren,
  output logic        eq_tx_done,
  output logic [7:0]  eq_read_ptr,
  input  logic [15:0] eq_dout,
  input  logic        eq_out_full,
  output logic        m_valid,
  output logic [15:0] m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic        err_timeout
);

  localparam int FIFO_DEPTH = READ_LAT + 1;
  localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);
  // One stage for the registered address plus READ_LAT stages of datapath latency
  localparam int PIPE       = READ_LAT + 1;
  localparam int OCC_W      = $clog2(PIPE + FIFO_DEPTH + 1);
  localparam int TMR_W      = $clog2(TIMEOUT + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(FIFO_DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;
  logic             err_q, err_d;

  logic [PIPE-1:0]  pipe_q;
  logic [7:0]       rd_addr_q;
  logic [15:0]      din_q;
  logic             wren_q;

  logic              w_hs;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;
  logic [FCNT_W-1:0] w_fifo_cnt;
  logic [OCC_W-1:0]  w_occ;

  assign s_ready = (state_q == ST_LOAD_CE) || (state_q == ST_LOAD_DATA);
  assign w_hs    = s_valid && s_ready;

  // Reset state is CLEAR, so state-decoded strobes are masked while rst is held
  assign eq_tx_done = (state_q == ST_CLEAR) && !rst;
  assign busy       = (state_q != ST_IDLE) && !rst;

  assign eq_din      = din_q;
  assign eq_wren     = wren_q;
  assign eq_read_ptr = rd_addr_q;
  assign err_timeout = err_q;

  // Data leaving the last latency stage is captured from the datapath
  assign w_push  = pipe_q[PIPE-1];
  assign m_valid = !w_fifo_empty;
  assign w_pop   = m_valid && m_ready;
  assign m_last  = m_valid && (out_idx_q == DATA_LAST);

  // Reads in flight plus words buffered; bounded by FIFO depth so no overflow
  always_comb begin
    w_occ = OCC_W'(w_fifo_cnt);
    for (int i = 0; i < PIPE; i++) begin
      w_occ = w_occ + OCC_W'(pipe_q[i]);
    end
  end

  assign w_issue = (state_q == ST_DRAIN) && (ptr_q < DATA_TOTAL) && (w_occ < OCC_MAX);

  // Next-state and counter logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    ptr_d     = ptr_q;
    out_idx_d = out_idx_q;
    err_d     = err_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (s_valid) begin
          cnt_d   = '0;
          state_d = ST_LOAD_CE;
        end
      end
      ST_LOAD_CE: begin
        if (w_hs) begin
          if (cnt_q == CE_LAST) begin
            cnt_d   = '0;
            state_d = ST_LOAD_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_LOAD_DATA: begin
        if (w_hs) begin
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = ST_WAIT_EQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT_EQ: begin
        // A full buffer wins over a coincident timeout
        if (eq_out_full) begin
          ptr_d     = '0;
          out_idx_d = '0;
          state_d   = ST_DRAIN;
        end else if (tmr_q == TMR_LAST) begin
          err_d   = 1'b1;
          state_d = ST_CLEAR;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (w_issue) begin
          ptr_d = ptr_q + CNT_W'(1);
        end
        if (w_pop) begin
          out_idx_d = out_idx_q + CNT_W'(1);
          if (out_idx_q == DATA_LAST) begin
            state_d = ST_CLEAR;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      tmr_q     <= '0;
      ptr_q     <= '0;
      out_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      ptr_q     <= ptr_d;
      out_idx_q <= out_idx_d;
      err_q     <= err_d;
    end
  end

  // Datapath write port, read address and read-latency tracker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q     <= '0;
      wren_q    <= 1'b0;
      rd_addr_q <= '0;
      pipe_q    <= '0;
    end else begin
      wren_q <= w_hs;
      if (w_hs) begin
        din_q <= s_data;
      end
      if (w_issue) begin
        rd_addr_q <= ptr_q;
      end
      pipe_q <= {pipe_q[PIPE-2:0], w_issue};
    end
  end

  ce_eq_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .din_i   (eq_dout),
    .pop_i   (w_pop),
    .dout_o  (m_data),
    .count_o (w_fifo_cnt),
    .empty_o (w_fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_ce_eq_burst_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ce_eq_burst_ctrl
// Description : Scoreboard bench for ce_eq_burst_ctrl with a READ_LAT=3
//               datapath read model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ce_eq_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic [15:0] eq_din;
  logic        eq_wren;
  logic        eq_tx_done;
  logic [7:0]  eq_read_ptr;
  logic [15:0] eq_dout = '0;
  logic        eq_out_full = 1'b0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic        busy;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] exp_wr_q[$];
  logic [16:0] exp_out_q[$];

  int  wr_count = 0;
  int  txd_pending = 0;
  bit  wr_seen = 1'b0;
  bit  rnd_mode = 1'b0;
  bit  stall_pending = 1'b0;
  logic [15:0] stall_data = '0;
  int  t_hs = 0;

  ce_eq_burst_ctrl #(.READ_LAT(3), .TIMEOUT(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .eq_din      (eq_din),
    .eq_wren     (eq_wren),
    .eq_tx_done  (eq_tx_done),
    .eq_read_ptr (eq_read_ptr),
    .eq_dout     (eq_dout),
    .eq_out_full (eq_out_full),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath output buffer: word p holds {p^8'h5A, p}, three-cycle read latency
  function automatic logic [15:0] f_word(input logic [7:0] p);
    return {p ^ 8'h5A, p};
  endfunction

  logic [15:0] d1 = '0, d2 = '0;
  always @(posedge clk) begin
    d1      <= f_word(eq_read_ptr);
    d2      <= d1;
    eq_dout <= d2;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always 1, or ready 30% of cycles in random mode
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Monitor: datapath writes, clear pulses, output stream and FIFO bound
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pending = 1'b0;
      end else begin
        if (eq_tx_done) begin
          txd_pending++;
          wr_seen = 1'b0;
        end
        if (eq_wren) begin
          wr_count++;
          if (!wr_seen) begin
            chk("tx_done_before_wren", 64'(txd_pending), 64'd1);
            wr_seen     = 1'b1;
            txd_pending = 0;
          end
          if (exp_wr_q.size() == 0) begin
            chk("wren_unexpected", 64'(eq_wren), 64'd0);
          end else begin
            chk("eq_din", 64'(eq_din), 64'(exp_wr_q.pop_front()));
          end
        end
        chk("fifo_bound", 64'((dut.u_fifo.count_o > 3'd4) ||
                              (dut.w_push && dut.u_fifo.count_o == 3'd4 && !dut.w_pop)), 64'd0);
        if (stall_pending) begin
          chk("m_valid_held", 64'(m_valid), 64'd1);
          chk("m_data_stable", 64'(m_data), 64'(stall_data));
        end
        stall_pending = m_valid && !m_ready;
        stall_data    = m_data;
        if (m_valid && m_ready) begin
          if (exp_out_q.size() == 0) begin
            chk("m_pop_unexpected", 64'(m_valid), 64'd0);
          end else begin
            logic [16:0] e;
            e = exp_out_q.pop_front();
            chk("m_data", 64'(m_data), 64'(e[15:0]));
            chk("m_last", 64'(m_last), 64'(e[16]));
          end
        end
      end
    end
  end

  task automatic send(input logic [15:0] d);
    bit ok;
    int guard;
    ok = 1'b0;
    guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) chk("s_handshake_timeout", 64'(ok), 64'd1);
    t_hs = cyc;
    exp_wr_q.push_back(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_wr_q.delete();
    txd_pending = 0;
    wr_seen     = 1'b0;
  endtask

  task automatic load_burst(input int base, input bit gap, input int abort_at);
    wr_count = 0;
    for (int i = 0; i < 336; i++) begin
      if (abort_at >= 0 && i == abort_at) begin
        s_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs",
            64'({s_ready, eq_din, eq_wren, eq_tx_done, eq_read_ptr, m_valid, m_data,
                 m_last, busy, err_timeout}), 64'd0);
        s_valid = 1'b0;
        do_reset();
        return;
      end
      send(16'(base + i));
      if (gap && i != 335) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    // Keep offering a sample: none may be accepted after the last handshake
    s_valid = 1'b1;
    @(negedge clk);
    chk("s_ready_after_last", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wren_count", 64'(wr_count), 64'd336);
  endtask

  task automatic drain(input int delay);
    int g;
    for (int k = 0; k < 224; k++) begin
      exp_out_q.push_back({(k == 223), f_word(8'(k))});
    end
    repeat (delay) @(posedge clk);
    #1;
    eq_out_full = 1'b1;
    g = 0;
    while (exp_out_q.size() != 0 && g < 5000) begin
      @(posedge clk);
      g++;
    end
    chk("drain_complete", 64'(exp_out_q.size()), 64'd0);
    exp_out_q.delete();
    #1;
    eq_out_full = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (busy && g < 100);
    chk("return_idle", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        64'({s_ready, eq_din, eq_wren, eq_tx_done, eq_read_ptr, m_valid, m_data,
             m_last, busy, err_timeout}), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Burst 1: back-to-back samples, m_ready=1
    load_burst(0, 1'b0, -1);
    drain(50);
    wait_idle();

    // Burst 2: s_valid every other cycle
    load_burst(1000, 1'b1, -1);
    drain(50);
    wait_idle();

    // Burst 3: downstream backpressure
    load_burst(2000, 1'b0, -1);
    rnd_mode = 1'b1;
    drain(50);
    rnd_mode = 1'b0;
    wait_idle();

    // Burst 4: no buffer-full, timeout after exactly 1024 WAIT_EQ cycles
    load_burst(3000, 1'b0, -1);
    while (cyc < t_hs + 1023) @(negedge clk);
    chk("err_before_timeout", 64'(err_timeout), 64'd0);
    @(negedge clk);
    chk("err_at_timeout", 64'(err_timeout), 64'd1);
    wait_idle();
    chk("err_sticky", 64'(err_timeout), 64'd1);

    // Burst 5: normal after timeout
    load_burst(4000, 1'b0, -1);
    drain(50);
    wait_idle();

    // Burst 6: reset at sample 150, then a full burst
    load_burst(5000, 1'b0, 150);
    chk("err_cleared_by_rst", 64'(err_timeout), 64'd0);
    load_burst(6000, 1'b0, -1);
    drain(50);
    wait_idle();

    // Bursts 8 and 9 with no idle gap
    load_burst(7000, 1'b0, -1);
    drain(50);
    load_burst(8000, 1'b0, -1);
    drain(50);
    wait_idle();

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
